mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MEMORY pipeline stage of the 5-stage RV32I core, directly downstream of the EXECUTE stage.
//  Consumes the registered E->M signals.
//  Performs byte/half/word data-memory loads and stores on a word-organised internal RAM.
//  Registers the M->W pipeline set and drives the write-back result mux (RSLT_W_o), which also feeds back to EXECUTE forwarding.
// PARAMETERS
//  ADDR_W   8   word-address width; RAM depth = 2**ADDR_W 32-bit words (byte range 0 .. 4*2**ADDR_W-1)
// PORTS
//  clk_i         in   1   clock, rising edge
//  rst_i         in   1   reset, asynchronous, active-low
//  REGWRT_M_i    in   1   register-file write enable from EXECUTE
//  RSLTSRC_M_i   in   2   result select: 00 ALU, 01 load data, 10 PC+4, 11 IMM
//  MEMWRT_M_i    in   1   store enable
//  FUNCT3_M_i    in   3   access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  ALURSLT_M_i   in   32  ALU result = byte address for loads/stores
//  RD2_M_i       in   32  store data (forwarded rs2)
//  PCPLUS4_M_i   in   32  PC+4 of the instruction
//  IMM_M_i       in   32  immediate (LUI path)
//  RD_M_i        in   5   destination register
//  REGWRT_W_o    out  1   registered, gated regwrite to the register file
//  RD_W_o        out  5   registered destination register
//  RSLT_W_o      out  32  write-back result (combinational mux of W registers)
//  FAULT_W_o     out  1   registered access-fault flag, one cycle per faulting instruction
// BEHAVIOUR
//  Access decode:
//   - load = (RSLTSRC_M_i==2'b01); store = MEMWRT_M_i.
//   - Word index = ALURSLT_M_i[ADDR_W+1:2]; byte lane = ALURSLT_M_i[1:0].
//  Fault, evaluated only when load or store is set:
//   - Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0.
//   - Out-of-range: addr >= 4*2**ADDR_W.
//   - Illegal FUNCT3: load codes other than {000,001,010,100,101}; store codes other than {000,001,010}.
//  Store: RAM written at the rising clk_i edge of the M cycle when store && !fault.
//   - SB writes RD2[7:0] into the lane selected by addr[1:0].
//   - SH writes RD2[15:0] into lanes {addr[1],0}.
//   - SW writes the full word.
//   - Unselected bytes are unchanged.
//   - A faulting store writes nothing.
//  Load: combinational RAM read in the M cycle.
//   - The selected byte/half is right-justified; sign-extended for B/H, zero-extended for BU/HU; W is passed whole.
//   - A faulting load yields data 0.
//   - Store then load to the same address in the next instruction returns the new data (write completes at the edge before the load's M cycle).
//  M->W registers, updated every rising edge (no stall/flush ports): REGWRT_W, RSLTSRC_W, RD_W, ALURSLT_W, LDDATA_W, PCPLUS4_W, IMM_W, FAULT_W.
//   - REGWRT_W = REGWRT_M_i & !fault; a faulting load never writes the register file.
//  RSLT_W_o = RSLTSRC_W ? {00:ALURSLT_W, 01:LDDATA_W, 10:PCPLUS4_W, 11:IMM_W}.
//  Latency: 1 cycle M->W for all outputs; the RAM write is visible to the next M-cycle read.
//  Reset (rst_i low, asynchronous):
//   - All W registers clear to 0, so REGWRT_W_o=0, RD_W_o=0, RSLT_W_o=0, FAULT_W_o=0.
//   - RAM contents are NOT cleared.
//   - Reset asserted during a store edge: the write is not guaranteed; the bench must not rely on it.
//  Simultaneous load and store: store takes effect; load data is the pre-write word.
//  Boundaries:
//   - The last word (index 2**ADDR_W-1) is accessible.
//   - Addr 4*2**ADDR_W faults.
//   - Addr 0xFFFFFFFF faults (out-of-range takes priority; the flag is still a single FAULT bit).
// TESTING
//  1 Reset: hold rst_i=0 two cycles -> REGWRT_W_o=0, RD_W_o=0, RSLT_W_o=0, FAULT_W_o=0.
//  2 SW 0x8000_00F1 @0x10, then LW @0x10, RD=5, RSLTSRC=01, REGWRT=1 -> next cycle RSLT_W_o=0x800000F1, RD_W_o=5, REGWRT_W_o=1.
//  3 SB 0xAB @0x21, then LB @0x21 -> RSLT_W_o=0xFFFFFFAB; LBU @0x21 -> 0x000000AB; LH @0x20 -> 0xFFFFAB00 (word preset to 0).
//  4 LW @0x12 (misaligned), REGWRT=1 -> FAULT_W_o=1 for one cycle, REGWRT_W_o=0, RSLT_W_o=0; SH @0x13 -> RAM unchanged.
//  5 SW @4*2**ADDR_W-4 then LW there -> data returned; SW @4*2**ADDR_W -> FAULT_W_o=1, no wrap-around write to word 0.
//  6 RSLTSRC=10, PCPLUS4=0x104 -> RSLT_W_o=0x104; RSLTSRC=11, IMM=0x12345000 -> RSLT_W_o=0x12345000; RSLTSRC=00, ALU=7 -> RSLT_W_o=7.

Source files
------------

// File: rtl/mem_access_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_stage_if
//  Purpose  : E->M inputs and M->W outputs of the MEMORY pipeline stage.
//  Revision : 1.0  initial release
// ============================================================================
interface mem_access_stage_if;
  logic        REGWRT_M_i;
  logic [1:0]  RSLTSRC_M_i;
  logic        MEMWRT_M_i;
  logic [2:0]  FUNCT3_M_i;
  logic [31:0] ALURSLT_M_i;
  logic [31:0] RD2_M_i;
  logic [31:0] PCPLUS4_M_i;
  logic [31:0] IMM_M_i;
  logic [4:0]  RD_M_i;
  logic        REGWRT_W_o;
  logic [4:0]  RD_W_o;
  logic [31:0] RSLT_W_o;
  logic        FAULT_W_o;

  // EXECUTE side drives the M signals and observes the W results
  modport master (
    output REGWRT_M_i, RSLTSRC_M_i, MEMWRT_M_i, FUNCT3_M_i, ALURSLT_M_i,
           RD2_M_i, PCPLUS4_M_i, IMM_M_i, RD_M_i,
    input  REGWRT_W_o, RD_W_o, RSLT_W_o, FAULT_W_o
  );

  modport slave (
    input  REGWRT_M_i, RSLTSRC_M_i, MEMWRT_M_i, FUNCT3_M_i, ALURSLT_M_i,
           RD2_M_i, PCPLUS4_M_i, IMM_M_i, RD_M_i,
    output REGWRT_W_o, RD_W_o, RSLT_W_o, FAULT_W_o
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_stage
//  Purpose  : RV32I MEMORY stage: byte/half/word access to an internal word
//             RAM, M->W pipeline registers and the write-back result mux.
//  Revision : 1.0  initial release
// ============================================================================
module mem_access_stage #(
  parameter int ADDR_W = 8
) (
  input  wire logic         clk_i,
  input  wire logic         rst_i,
  mem_access_stage_if.slave bus
);

  localparam int         c_DEPTH    = 2**ADDR_W;
  localparam logic [1:0] c_SRC_ALU  = 2'b00;
  localparam logic [1:0] c_SRC_LOAD = 2'b01;
  localparam logic [1:0] c_SRC_PC4  = 2'b10;
  localparam logic [2:0] c_F3_B     = 3'b000;
  localparam logic [2:0] c_F3_H     = 3'b001;
  localparam logic [2:0] c_F3_W     = 3'b010;
  localparam logic [2:0] c_F3_BU    = 3'b100;
  localparam logic [2:0] c_F3_HU    = 3'b101;

  logic [31:0] r_mem [c_DEPTH];

  logic [ADDR_W-1:0] w_idx;
  logic [1:0]        w_lane;
  logic [2:0]        w_f3;
  logic              w_load;
  logic              w_store;
  logic              w_misalign;
  logic              w_oor;
  logic              w_bad_ld;
  logic              w_bad_st;
  logic              w_fault;
  logic              w_we;
  logic [31:0]       w_word;
  logic [7:0]        w_ld_byte;
  logic [15:0]       w_ld_half;
  logic [31:0]       w_lddata;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;

  logic              r_regwrt_w;
  logic [1:0]        r_rsltsrc_w;
  logic [4:0]        r_rd_w;
  logic [31:0]       r_alurslt_w;
  logic [31:0]       r_lddata_w;
  logic [31:0]       r_pcplus4_w;
  logic [31:0]       r_imm_w;
  logic              r_fault_w;

  assign w_idx  = bus.ALURSLT_M_i[ADDR_W+1:2];
  assign w_lane = bus.ALURSLT_M_i[1:0];
  assign w_f3   = bus.FUNCT3_M_i;

  // Access decode and fault detection
  always_comb begin
    w_load     = (bus.RSLTSRC_M_i == c_SRC_LOAD);
    w_store    = bus.MEMWRT_M_i;
    w_misalign = ((w_f3[1:0] == 2'b01) && w_lane[0]) ||
                 ((w_f3 == c_F3_W) && (w_lane != 2'b00));
    w_oor      = |bus.ALURSLT_M_i[31:ADDR_W+2];
    w_bad_ld   = 1'b1;
    w_bad_st   = 1'b1;
    case (w_f3)
      c_F3_B, c_F3_H, c_F3_W: begin
        w_bad_ld = 1'b0;
        w_bad_st = 1'b0;
      end
      c_F3_BU, c_F3_HU: w_bad_ld = 1'b0;
      default: ;
    endcase
    w_fault = (w_load || w_store) &&
              (w_misalign || w_oor || (w_load && w_bad_ld) || (w_store && w_bad_st));
    w_we    = w_store && !w_fault;
  end

  // Combinational read; a simultaneous store sees the pre-write word
  always_comb begin
    w_word = r_mem[w_idx];
    case (w_lane)
      2'b00:   w_ld_byte = w_word[7:0];
      2'b01:   w_ld_byte = w_word[15:8];
      2'b10:   w_ld_byte = w_word[23:16];
      default: w_ld_byte = w_word[31:24];
    endcase
    w_ld_half = w_lane[1] ? w_word[31:16] : w_word[15:0];
    w_lddata  = 32'h0;
    if (!w_fault) begin
      case (w_f3)
        c_F3_B:  w_lddata = {{24{w_ld_byte[7]}}, w_ld_byte};
        c_F3_H:  w_lddata = {{16{w_ld_half[15]}}, w_ld_half};
        c_F3_W:  w_lddata = w_word;
        c_F3_BU: w_lddata = {24'h0, w_ld_byte};
        c_F3_HU: w_lddata = {16'h0, w_ld_half};
        default: w_lddata = 32'h0;
      endcase
    end
  end

  // Store lane enables with the data replicated across all lanes
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = bus.RD2_M_i;
    case (w_f3)
      c_F3_B: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{bus.RD2_M_i[7:0]}};
      end
      c_F3_H: begin
        w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{bus.RD2_M_i[15:0]}};
      end
      c_F3_W:  w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  // RAM contents survive reset, so this array has no reset branch
  always_ff @(posedge clk_i) begin
    if (w_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_regwrt_w  <= 1'b0;
      r_rsltsrc_w <= 2'b00;
      r_rd_w      <= 5'd0;
      r_alurslt_w <= 32'h0;
      r_lddata_w  <= 32'h0;
      r_pcplus4_w <= 32'h0;
      r_imm_w     <= 32'h0;
      r_fault_w   <= 1'b0;
    end else begin
      r_regwrt_w  <= bus.REGWRT_M_i && !w_fault;
      r_rsltsrc_w <= bus.RSLTSRC_M_i;
      r_rd_w      <= bus.RD_M_i;
      r_alurslt_w <= bus.ALURSLT_M_i;
      r_lddata_w  <= w_lddata;
      r_pcplus4_w <= bus.PCPLUS4_M_i;
      r_imm_w     <= bus.IMM_M_i;
      r_fault_w   <= w_fault;
    end
  end

  always_comb begin
    case (r_rsltsrc_w)
      c_SRC_ALU:  bus.RSLT_W_o = r_alurslt_w;
      c_SRC_LOAD: bus.RSLT_W_o = r_lddata_w;
      c_SRC_PC4:  bus.RSLT_W_o = r_pcplus4_w;
      default:    bus.RSLT_W_o = r_imm_w;
    endcase
  end

  assign bus.REGWRT_W_o = r_regwrt_w;
  assign bus.RD_W_o     = r_rd_w;
  assign bus.FAULT_W_o  = r_fault_w;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_stage
//  Purpose  : Random and directed stimulus for mem_access_stage against a
//             byte-addressed reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_access_stage;

  localparam int ADDR_W  = 8;
  localparam int c_BYTES = 4 * (2**ADDR_W);

  typedef struct {
    logic        regwrt;
    logic [1:0]  src;
    logic        memwrt;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] rd2;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic [4:0]  rd;
  } op_t;

  typedef struct {
    logic        regwrt;
    logic [4:0]  rd;
    logic [31:0] rslt;
    logic        fault;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic [7:0] mem_b [c_BYTES];
  exp_t       exp_q [$];

  always #5 clk_i = ~clk_i;

  mem_access_stage_if bus ();

  mem_access_stage #(.ADDR_W(ADDR_W)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference behaviour over a byte array: fault rules, load value, store effect
  task automatic model_apply(input op_t o, output exp_t e);
    bit          ld = (o.src == 2'b01);
    bit          st = o.memwrt;
    int          sz = (o.f3[1:0] == 2'b00) ? 1 : (o.f3[1:0] == 2'b01) ? 2 : 4;
    bit          fault = 1'b0;
    logic [31:0] v = 32'h0;
    if (ld || st) begin
      if (ld && !(o.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) fault = 1'b1;
      if (st && !(o.f3 inside {3'd0, 3'd1, 3'd2})) fault = 1'b1;
      if ((o.alu % sz) != 0) fault = 1'b1;
      if (o.alu >= c_BYTES) fault = 1'b1;
    end
    if (ld && !fault) begin
      for (int i = 0; i < sz; i++) v = v | (32'(mem_b[o.alu + i]) << (8 * i));
      if (!o.f3[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
      if (!o.f3[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
    end
    if (st && !fault) begin
      for (int i = 0; i < sz; i++) mem_b[o.alu + i] = o.rd2[8*i +: 8];
    end
    e.regwrt = o.regwrt && !fault;
    e.rd     = o.rd;
    e.fault  = fault;
    case (o.src)
      2'b00:   e.rslt = o.alu;
      2'b01:   e.rslt = v;
      2'b10:   e.rslt = o.pc4;
      default: e.rslt = o.imm;
    endcase
  endtask

  task automatic set_idle();
    bus.REGWRT_M_i  = 1'b0;
    bus.RSLTSRC_M_i = 2'b00;
    bus.MEMWRT_M_i  = 1'b0;
    bus.FUNCT3_M_i  = 3'b000;
    bus.ALURSLT_M_i = 32'h0;
    bus.RD2_M_i     = 32'h0;
    bus.PCPLUS4_M_i = 32'h0;
    bus.IMM_M_i     = 32'h0;
    bus.RD_M_i      = 5'd0;
  endtask

  task automatic drive(input op_t o);
    exp_t e;
    @(negedge clk_i);
    bus.REGWRT_M_i  = o.regwrt;
    bus.RSLTSRC_M_i = o.src;
    bus.MEMWRT_M_i  = o.memwrt;
    bus.FUNCT3_M_i  = o.f3;
    bus.ALURSLT_M_i = o.alu;
    bus.RD2_M_i     = o.rd2;
    bus.PCPLUS4_M_i = o.pc4;
    bus.IMM_M_i     = o.imm;
    bus.RD_M_i      = o.rd;
    model_apply(o, e);
    exp_q.push_back(e);
  endtask

  function automatic op_t mk(input logic regwrt, input logic [1:0] src, input logic memwrt,
                             input logic [2:0] f3, input logic [31:0] alu,
                             input logic [31:0] rd2, input logic [4:0] rd);
    op_t o;
    o.regwrt = regwrt; o.src = src; o.memwrt = memwrt; o.f3 = f3;
    o.alu = alu; o.rd2 = rd2; o.rd = rd;
    o.pc4 = $urandom; o.imm = $urandom;
    return o;
  endfunction

  function automatic op_t st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    return mk(1'b0, 2'b00, 1'b1, f3, a, d, 5'd0);
  endfunction

  function automatic op_t ld(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd);
    return mk(1'b1, 2'b01, 1'b0, f3, a, 32'h0, rd);
  endfunction

  function automatic op_t rnd_op();
    op_t         o;
    logic [31:0] a;
    logic [2:0]  legal [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    case ($urandom_range(0, 9))
      0:       a = 32'(c_BYTES - 4 + $urandom_range(0, 3));
      1:       a = 32'(c_BYTES + $urandom_range(0, 7));
      2:       a = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      3:       a = $urandom;
      4:       a = 32'($urandom_range(0, c_BYTES - 1));
      default: a = 32'($urandom_range(0, 63));
    endcase
    o = mk(1'($urandom), 2'($urandom), ($urandom_range(0, 2) == 0), 3'd0, a, $urandom,
           5'($urandom));
    o.f3 = ($urandom_range(0, 9) < 7) ? legal[$urandom_range(0, 4)] : 3'($urandom);
    return o;
  endfunction

  task automatic settle();
    @(posedge clk_i);
    #2;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_regwrt"}, 32'(bus.REGWRT_W_o), 32'h0);
    chk({tag, "_rd"},     32'(bus.RD_W_o),     32'h0);
    chk({tag, "_rslt"},   bus.RSLT_W_o,        32'h0);
    chk({tag, "_fault"},  32'(bus.FAULT_W_o),  32'h0);
  endtask

  // Single compare point: one cycle after each driven instruction
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (!rst_i) begin
        exp_q.delete();
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("regwrt_w", 32'(bus.REGWRT_W_o), 32'(e.regwrt));
        chk("rd_w",     32'(bus.RD_W_o),     32'(e.rd));
        chk("rslt_w",   bus.RSLT_W_o,        e.rslt);
        chk("fault_w",  32'(bus.FAULT_W_o),  32'(e.fault));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    op_t o;
    set_idle();
    rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk_zero("reset");
    @(negedge clk_i);
    rst_i = 1'b1;

    for (int w = 0; w < 2**ADDR_W; w++) drive(st(3'd2, 32'(w * 4), $urandom));

    drive(st(3'd2, 32'h10, 32'h8000_00F1));
    drive(ld(3'd2, 32'h10, 5'd5));
    settle();
    chk("lw_rslt", bus.RSLT_W_o, 32'h8000_00F1);
    chk("lw_rd", 32'(bus.RD_W_o), 32'd5);
    chk("lw_regwrt", 32'(bus.REGWRT_W_o), 32'd1);

    drive(st(3'd2, 32'h20, 32'h0));
    drive(st(3'd0, 32'h21, 32'hAB));
    drive(ld(3'd0, 32'h21, 5'd1));
    settle();
    chk("lb_rslt", bus.RSLT_W_o, 32'hFFFF_FFAB);
    drive(ld(3'd4, 32'h21, 5'd2));
    settle();
    chk("lbu_rslt", bus.RSLT_W_o, 32'h0000_00AB);
    drive(ld(3'd1, 32'h20, 5'd3));
    settle();
    chk("lh_rslt", bus.RSLT_W_o, 32'hFFFF_AB00);

    drive(st(3'd2, 32'h10, 32'h0102_0304));
    drive(ld(3'd2, 32'h12, 5'd7));
    settle();
    chk("mis_fault", 32'(bus.FAULT_W_o), 32'd1);
    chk("mis_regwrt", 32'(bus.REGWRT_W_o), 32'd0);
    chk("mis_rslt", bus.RSLT_W_o, 32'h0);
    drive(st(3'd1, 32'h13, 32'hFFFF));
    settle();
    chk("sh_mis_fault", 32'(bus.FAULT_W_o), 32'd1);
    drive(ld(3'd2, 32'h10, 5'd8));
    settle();
    chk("sh_mis_nowrite", bus.RSLT_W_o, 32'h0102_0304);
    chk("fault_one_cycle", 32'(bus.FAULT_W_o), 32'd0);

    drive(st(3'd2, 32'h0, 32'h1111_1111));
    drive(st(3'd2, 32'(c_BYTES - 4), 32'hCAFE_F00D));
    drive(ld(3'd2, 32'(c_BYTES - 4), 5'd9));
    settle();
    chk("last_word", bus.RSLT_W_o, 32'hCAFE_F00D);
    drive(st(3'd2, 32'(c_BYTES), 32'hDEAD_BEEF));
    settle();
    chk("oor_fault", 32'(bus.FAULT_W_o), 32'd1);
    drive(ld(3'd2, 32'h0, 5'd10));
    settle();
    chk("no_wrap", bus.RSLT_W_o, 32'h1111_1111);
    drive(ld(3'd0, 32'hFFFF_FFFF, 5'd11));
    settle();
    chk("ffff_fault", 32'(bus.FAULT_W_o), 32'd1);

    drive(st(3'd2, 32'h40, 32'hAAAA_AAAA));
    o = mk(1'b1, 2'b01, 1'b1, 3'd2, 32'h40, 32'h5555_5555, 5'd12);
    drive(o);
    settle();
    chk("ldst_pre", bus.RSLT_W_o, 32'hAAAA_AAAA);
    drive(ld(3'd2, 32'h40, 5'd13));
    settle();
    chk("ldst_post", bus.RSLT_W_o, 32'h5555_5555);

    o = mk(1'b1, 2'b10, 1'b0, 3'd0, 32'h0, 32'h0, 5'd1);
    o.pc4 = 32'h104;
    drive(o);
    settle();
    chk("src_pc4", bus.RSLT_W_o, 32'h104);
    o = mk(1'b1, 2'b11, 1'b0, 3'd0, 32'h0, 32'h0, 5'd1);
    o.imm = 32'h1234_5000;
    drive(o);
    settle();
    chk("src_imm", bus.RSLT_W_o, 32'h1234_5000);
    drive(mk(1'b1, 2'b00, 1'b0, 3'd0, 32'd7, 32'h0, 5'd1));
    settle();
    chk("src_alu", bus.RSLT_W_o, 32'd7);

    for (int n = 0; n < 2000; n++) drive(rnd_op());

    // Asynchronous reset mid-cycle, RAM must keep its contents
    @(posedge clk_i);
    #3;
    set_idle();
    rst_i = 1'b0;
    #1;
    chk_zero("async_rst");
    @(negedge clk_i);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    drive(ld(3'd2, 32'h40, 5'd14));
    settle();
    chk("ram_kept", bus.RSLT_W_o, 32'h5555_5555);

    for (int n = 0; n < 300; n++) drive(rnd_op());
    settle();
    settle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
